// File: rtl/lane_pipe_reg.sv
// Multi-lane elastic pipeline register: DEPTH stages of LANES x DATA_W under one valid/ready handshake.
// Optional per-lane parity sideband enabled by defining LANE_PIPE_PARITY_EN.
module lane_pipe_reg #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clkf,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready
`ifdef LANE_PIPE_PARITY_EN
  ,
  output logic [LANES-1:0]        out_parity
`endif
);

  localparam int unsigned W = LANES * DATA_W;

  logic [DEPTH-1:0] v_q, v_d;
  logic [W-1:0]     d_q [DEPTH];
  logic [W-1:0]     d_d [DEPTH];
  logic [DEPTH:0]   rdy_c;
  logic [W-1:0]     masked_c;
`ifdef LANE_PIPE_PARITY_EN
  logic [LANES-1:0] p_q [DEPTH];
  logic [LANES-1:0] p_d [DEPTH];
  logic [LANES-1:0] par_c;
`endif

  // Lane masking (and parity) of the incoming word, applied only at stage-0 capture.
  always_comb begin
    masked_c = '0;
`ifdef LANE_PIPE_PARITY_EN
    par_c = '0;
`endif
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_en[k]) begin
        masked_c[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
      end
`ifdef LANE_PIPE_PARITY_EN
      par_c[k] = ^masked_c[k*DATA_W +: DATA_W];
`endif
    end
  end

  // Ready chain, walked from the output back; a running term avoids a self-referencing vector.
  always_comb begin
    logic r;
    r            = out_ready;
    rdy_c        = '0;
    rdy_c[DEPTH] = r;
    for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
      r        = ~v_q[s] | r;
      rdy_c[s] = r;
    end
  end

  assign in_ready  = rdy_c[0] & ~flush & reset;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
`ifdef LANE_PIPE_PARITY_EN
  assign out_parity = p_q[DEPTH-1];
`endif

  // Next-state: advance where downstream is ready, otherwise hold; flush clears everything.
  always_comb begin
    v_d = v_q;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      d_d[s] = d_q[s];
`ifdef LANE_PIPE_PARITY_EN
      p_d[s] = p_q[s];
`endif
    end

    if (rdy_c[0]) begin
      v_d[0] = in_valid;
      d_d[0] = in_valid ? masked_c : '0;
`ifdef LANE_PIPE_PARITY_EN
      p_d[0] = in_valid ? par_c : '0;
`endif
    end

    // Empty stages already hold zero data, so shifting keeps data clean.
    for (int unsigned s = 1; s < DEPTH; s++) begin
      if (rdy_c[s]) begin
        v_d[s] = v_q[s-1];
        d_d[s] = d_q[s-1];
`ifdef LANE_PIPE_PARITY_EN
        p_d[s] = p_q[s-1];
`endif
      end
    end

    if (flush) begin
      v_d = '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        d_d[s] = '0;
`ifdef LANE_PIPE_PARITY_EN
        p_d[s] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clkf) begin
    if (!reset) begin
      v_q <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        d_q[s] <= '0;
`ifdef LANE_PIPE_PARITY_EN
        p_q[s] <= '0;
`endif
      end
    end else begin
      v_q <= v_d;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        d_q[s] <= d_d[s];
`ifdef LANE_PIPE_PARITY_EN
        p_q[s] <= p_d[s];
`endif
      end
    end
  end

endmodule

// File: tb/tb_lane_pipe_reg.sv
// Directed self-checking bench for lane_pipe_reg (LANES=2, DATA_W=8, DEPTH=2).
// Parity checks are compiled in when LANE_PIPE_PARITY_EN is defined.
module tb_lane_pipe_reg;

  logic        clkf = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  lane_en;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
`ifdef LANE_PIPE_PARITY_EN
  logic [1:0]  out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lane_pipe_reg #(.LANES(2), .DATA_W(8), .DEPTH(2)) dut (
    .clkf      (clkf),
    .reset     (reset),
    .flush     (flush),
    .lane_en   (lane_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef LANE_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clkf = ~clkf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clkf);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; lane_en = 2'b11;
    in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1;
    settle();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready2", 32'(in_ready), 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    settle();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: two back-to-back words, out_ready high
    in_valid = 1'b1; in_data = 16'h3CA5;
    tick();
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    in_data = 16'h2211;
    tick();
    in_valid = 1'b0;
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_data", 32'(out_data), 32'h3CA5);
    tick();
    chk("lat_c3_valid", 32'(out_valid), 32'd1);
    chk("lat_c3_data", 32'(out_data), 32'h2211);
    tick();
    chk("lat_c4_valid", 32'(out_valid), 32'd0);
    chk("lat_c4_data", 32'(out_data), 32'd0);

    // Backpressure, then full pop+push
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    settle();
    chk("bp_rdy_w1", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'h2222;
    settle();
    chk("bp_rdy_w2", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'h3333;
    settle();
    chk("bp_rdy_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_data", 32'(out_data), 32'h1111);
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    settle();
    chk("pp_rdy_comb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    settle();
    chk("pp_data_w2", 32'(out_data), 32'h2222);
    chk("pp_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_data_w3", 32'(out_data), 32'h3333);
    chk("bp_valid_w3", 32'(out_valid), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush with two words in flight and a word offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h4444;
    tick();
    in_data = 16'h5555;
    tick();
    flush = 1'b1; in_data = 16'h6666;
    settle();
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data", 32'(out_data), 32'd0);
    tick();
    chk("fl_no_capture", 32'(out_valid), 32'd0);

    // Same again with reset
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7777;
    tick();
    in_data = 16'h8888;
    tick();
    reset = 1'b0; in_data = 16'h9999;
    settle();
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_data", 32'(out_data), 32'd0);
    tick();
    chk("rs_no_capture", 32'(out_valid), 32'd0);

    // Lane mask sampled at capture only
    lane_en = 2'b01; in_valid = 1'b1; in_data = 16'hFFFF;
    tick();
    lane_en = 2'b11; in_valid = 1'b0;
    tick();
    chk("mask_data", 32'(out_data), 32'h00FF);
`ifdef LANE_PIPE_PARITY_EN
    chk("mask_parity", 32'(out_parity), 32'd0);
`endif
    in_valid = 1'b1; in_data = 16'h0301;
    tick();
    in_valid = 1'b0;
    tick();
    chk("par_word_data", 32'(out_data), 32'h0301);
`ifdef LANE_PIPE_PARITY_EN
    chk("par_word_parity", 32'(out_parity), 32'b01);
`endif
    tick();
    chk("mask_drained", 32'(out_valid), 32'd0);

    // Bubble collapse under a stalled output
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("bub_a_valid", 32'(out_valid), 32'd1);
    chk("bub_a_data", 32'(out_data), 32'hAAAA);
    in_valid = 1'b1; in_data = 16'hBBBB;
    settle();
    chk("bub_accept_b", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    chk("bub_full", 32'(in_ready), 32'd0);
    chk("bub_a_held", 32'(out_data), 32'hAAAA);
    out_ready = 1'b1;
    tick();
    chk("bub_b_data", 32'(out_data), 32'hBBBB);
    tick();
    chk("bub_drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
